// File: rtl/alu_cdb_if.sv
// Issue bus from the reservation station into the ALU, and the ALU result broadcast bus
// that feeds RS/LSB wake-up and the ROB.
interface alu_cdb_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int INS_W  = 6
);
    logic              ari_ins_flag;
    logic [INS_W-1:0]  ari_insty;
    logic [DATA_W-1:0] ari_val1;
    logic [DATA_W-1:0] ari_val2;
    logic [ROB_W-1:0]  ari_ROB_idx;

    logic              val_flag_RS;
    logic [ROB_W-1:0]  val_idx_RS;
    logic [DATA_W-1:0] val_RS;

    // RS side: issues ops and listens to broadcasts.
    modport master (
        output ari_ins_flag, ari_insty, ari_val1, ari_val2, ari_ROB_idx,
        input  val_flag_RS, val_idx_RS, val_RS
    );

    // ALU side: consumes ops and drives the broadcast.
    modport slave (
        input  ari_ins_flag, ari_insty, ari_val1, ari_val2, ari_ROB_idx,
        output val_flag_RS, val_idx_RS, val_RS
    );
endinterface

// File: rtl/alu_cdb_stage.sv
// Single-cycle ALU/branch/JALR execution stage: computes the result of an issued op and
// broadcasts {flag, ROB idx, value} one cycle later on the common data bus.
package alu_cdb_pkg;
    typedef enum logic [5:0] {
        INS_NONE  = 6'd0,
        INS_LUI   = 6'd1,
        INS_AUIPC = 6'd2,
        INS_JALR  = 6'd3,
        INS_BEQ   = 6'd4,
        INS_BNE   = 6'd5,
        INS_BLT   = 6'd6,
        INS_BGE   = 6'd7,
        INS_BLTU  = 6'd8,
        INS_BGEU  = 6'd9,
        INS_ADDI  = 6'd10,
        INS_SLTI  = 6'd11,
        INS_SLTIU = 6'd12,
        INS_XORI  = 6'd13,
        INS_ORI   = 6'd14,
        INS_ANDI  = 6'd15,
        INS_SLLI  = 6'd16,
        INS_SRLI  = 6'd17,
        INS_SRAI  = 6'd18,
        INS_ADD   = 6'd19,
        INS_SUB   = 6'd20,
        INS_SLL   = 6'd21,
        INS_SLT   = 6'd22,
        INS_SLTU  = 6'd23,
        INS_XOR   = 6'd24,
        INS_SRL   = 6'd25,
        INS_SRA   = 6'd26,
        INS_OR    = 6'd27,
        INS_AND   = 6'd28
    } ins_t;
endpackage

module alu_cdb_stage
    import alu_cdb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int INS_W  = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         jp_wrong,
    alu_cdb_if.slave     bus
);
    logic [INS_W-1:0]  insty;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] result;

    logic              flag_q;
    logic [ROB_W-1:0]  idx_q;
    logic [DATA_W-1:0] val_q;

    assign insty = bus.ari_insty;
    assign v1    = bus.ari_val1;
    assign v2    = bus.ari_val2;
    assign shamt = v2[4:0];
    assign sum   = v1 + v2;

    // NOTE: result is assigned a default before the case so no path leaves it unassigned;
    // otherwise synthesis would infer a latch for unlisted codes.
    always_comb begin
        result = '0;
        case (insty)
            INS_ADD, INS_ADDI, INS_AUIPC: result = sum;
            INS_SUB:                      result = v1 - v2;
            INS_AND, INS_ANDI:            result = v1 & v2;
            INS_OR,  INS_ORI:             result = v1 | v2;
            INS_XOR, INS_XORI:            result = v1 ^ v2;
            INS_SLL, INS_SLLI:            result = v1 << shamt;
            INS_SRL, INS_SRLI:            result = v1 >> shamt;
            INS_SRA, INS_SRAI:            result = $signed(v1) >>> shamt;
            INS_SLT, INS_SLTI:            result = DATA_W'($signed(v1) < $signed(v2));
            INS_SLTU, INS_SLTIU:          result = DATA_W'(v1 < v2);
            INS_LUI:                      result = v2;
            INS_BEQ:                      result = DATA_W'(v1 == v2);
            INS_BNE:                      result = DATA_W'(v1 != v2);
            INS_BLT:                      result = DATA_W'($signed(v1) < $signed(v2));
            INS_BGE:                      result = DATA_W'($signed(v1) >= $signed(v2));
            INS_BLTU:                     result = DATA_W'(v1 < v2);
            INS_BGEU:                     result = DATA_W'(v1 >= v2);
            INS_JALR:                     result = sum & ~DATA_W'(1);
            default:                      result = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q <= 1'b0;
            idx_q  <= '0;
            val_q  <= '0;
        end else if (rdy) begin
            // A flush kills the op being issued this cycle; idx/value may go stale.
            if (jp_wrong || !bus.ari_ins_flag) begin
                flag_q <= 1'b0;
            end else begin
                flag_q <= 1'b1;
                idx_q  <= bus.ari_ROB_idx;
                val_q  <= result;
            end
        end
    end

    assign bus.val_flag_RS = flag_q;
    assign bus.val_idx_RS  = idx_q;
    assign bus.val_RS      = val_q;
endmodule

// File: tb/tb_alu_cdb_stage.sv
// Directed, table-driven bench for alu_cdb_stage: per-op result vectors plus flush,
// stall and asynchronous-reset sequences.
module tb_alu_cdb_stage;
    import alu_cdb_pkg::*;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 4;
    localparam int INS_W  = 6;

    logic clk;
    logic rst;
    logic rdy;
    logic jp_wrong;

    int errors;
    int checks;

    alu_cdb_if #(.DATA_W(DATA_W), .ROB_W(ROB_W), .INS_W(INS_W)) bus ();

    alu_cdb_stage #(.DATA_W(DATA_W), .ROB_W(ROB_W), .INS_W(INS_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .jp_wrong (jp_wrong),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        ins_t        ins;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [3:0]  idx;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, cross the rising edge, then settle before sampling.
    task automatic cycle(input logic f, input ins_t ins, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [3:0] idx,
                         input logic jp, input logic r);
        bus.ari_ins_flag = f;
        bus.ari_insty    = ins;
        bus.ari_val1     = v1;
        bus.ari_val2     = v2;
        bus.ari_ROB_idx  = idx;
        jp_wrong         = jp;
        rdy              = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic f, input logic [3:0] idx,
                             input logic [31:0] val);
        check({name, ".flag"}, 32'(bus.val_flag_RS), 32'(f));
        check({name, ".idx"},  32'(bus.val_idx_RS),  32'(idx));
        check({name, ".val"},  bus.val_RS,           val);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{"add_wrap",  INS_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 4'd3,  32'h8000_0000};
        vecs[1]  = '{"sra",       INS_SRA,   32'h8000_0000, 32'h0000_0024, 4'd4,  32'hF800_0000};
        vecs[2]  = '{"sltu",      INS_SLTU,  32'h0000_0001, 32'hFFFF_FFFF, 4'd5,  32'h0000_0001};
        vecs[3]  = '{"blt",       INS_BLT,   32'hFFFF_FFFF, 32'h0000_0000, 4'd6,  32'h0000_0001};
        vecs[4]  = '{"bltu",      INS_BLTU,  32'hFFFF_FFFF, 32'h0000_0000, 4'd7,  32'h0000_0000};
        vecs[5]  = '{"jalr",      INS_JALR,  32'h0000_1001, 32'h0000_0004, 4'd8,  32'h0000_1004};
        vecs[6]  = '{"sub",       INS_SUB,   32'h0000_0005, 32'h0000_0007, 4'd9,  32'hFFFF_FFFE};
        vecs[7]  = '{"and",       INS_AND,   32'h0000_F0F0, 32'h0000_0FF0, 4'd10, 32'h0000_00F0};
        vecs[8]  = '{"ori",       INS_ORI,   32'h0000_0F00, 32'h0000_000F, 4'd11, 32'h0000_0F0F};
        vecs[9]  = '{"xori",      INS_XORI,  32'h0000_00FF, 32'h0000_000F, 4'd12, 32'h0000_00F0};
        vecs[10] = '{"sll_mask",  INS_SLL,   32'h0000_0001, 32'h0000_0021, 4'd13, 32'h0000_0002};
        vecs[11] = '{"srli",      INS_SRLI,  32'h8000_0000, 32'h0000_001F, 4'd14, 32'h0000_0001};
        vecs[12] = '{"slt",       INS_SLT,   32'hFFFF_FFFE, 32'h0000_0001, 4'd15, 32'h0000_0001};
        vecs[13] = '{"slti",      INS_SLTI,  32'h0000_0005, 32'hFFFF_FFFF, 4'd0,  32'h0000_0000};
        vecs[14] = '{"lui",       INS_LUI,   32'hDEAD_BEEF, 32'h1234_5000, 4'd1,  32'h1234_5000};
        vecs[15] = '{"auipc",     INS_AUIPC, 32'h0000_1000, 32'h0000_2000, 4'd2,  32'h0000_3000};
        vecs[16] = '{"beq",       INS_BEQ,   32'h0000_0005, 32'h0000_0005, 4'd3,  32'h0000_0001};
        vecs[17] = '{"bne",       INS_BNE,   32'h0000_0005, 32'h0000_0005, 4'd4,  32'h0000_0000};
        vecs[18] = '{"bge",       INS_BGE,   32'h0000_0000, 32'hFFFF_FFFF, 4'd5,  32'h0000_0001};
        vecs[19] = '{"bgeu",      INS_BGEU,  32'h0000_0000, 32'hFFFF_FFFF, 4'd6,  32'h0000_0000};
        vecs[20] = '{"srai_pos",  INS_SRAI,  32'h4000_0000, 32'h0000_0002, 4'd7,  32'h1000_0000};
        vecs[21] = '{"unknown",   ins_t'(6'h3F), 32'h1234_5678, 32'h1, 4'd8, 32'h0000_0000};

        rst              = 1'b0;
        rdy              = 1'b1;
        jp_wrong         = 1'b0;
        bus.ari_ins_flag = 1'b0;
        bus.ari_insty    = INS_NONE;
        bus.ari_val1     = '0;
        bus.ari_val2     = '0;
        bus.ari_ROB_idx  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 4'd0, 32'h0);
        rst = 1'b1;
        cycle(1'b0, INS_NONE, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1);
        check_out("post_reset_idle", 1'b0, 4'd0, 32'h0);

        // Back-to-back issue: each result appears exactly one edge after its issue.
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].ins, vecs[i].v1, vecs[i].v2, vecs[i].idx, 1'b0, 1'b1);
            check_out(vecs[i].name, 1'b1, vecs[i].idx, vecs[i].exp);
        end
        cycle(1'b0, INS_NONE, 32'h0, 32'h0, 4'd0, 1'b0, 1'b1);
        check("idle_after_burst.flag", 32'(bus.val_flag_RS), 32'h0);

        // Flush on the issue cycle discards the op; re-issue is then broadcast.
        cycle(1'b1, INS_SUB, 32'h5, 32'h7, 4'd2, 1'b1, 1'b1);
        check("flush.flag", 32'(bus.val_flag_RS), 32'h0);
        cycle(1'b1, INS_SUB, 32'h5, 32'h7, 4'd2, 1'b0, 1'b1);
        check_out("reissue", 1'b1, 4'd2, 32'hFFFF_FFFE);

        // Stall: outputs freeze while rdy=0 even with a valid op and a flush pending.
        cycle(1'b1, INS_XOR, 32'hFF, 32'h0F, 4'd9, 1'b0, 1'b1);
        check_out("xor", 1'b1, 4'd9, 32'h0000_00F0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, INS_ADD, 32'h10, 32'h20, 4'd11, (k == 2), 1'b0);
            check_out($sformatf("stall%0d", k), 1'b1, 4'd9, 32'h0000_00F0);
        end
        cycle(1'b1, INS_ADD, 32'h10, 32'h20, 4'd11, 1'b0, 1'b1);
        check_out("resume", 1'b1, 4'd11, 32'h0000_0030);

        // Asynchronous reset between edges drops the pending broadcast immediately.
        cycle(1'b1, INS_OR, 32'hA0, 32'h05, 4'd6, 1'b0, 1'b1);
        check_out("pre_async", 1'b1, 4'd6, 32'h0000_00A5);
        #2;
        rst = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 4'd0, 32'h0);
        cycle(1'b1, INS_ADD, 32'h1, 32'h1, 4'd5, 1'b0, 1'b1);
        check_out("held_in_reset", 1'b0, 4'd0, 32'h0);
        rst = 1'b1;
        cycle(1'b0, INS_ADD, 32'h1, 32'h1, 4'd5, 1'b0, 1'b1);
        check_out("idle_after_reset", 1'b0, 4'd0, 32'h0);
        cycle(1'b1, INS_ADD, 32'h1, 32'h1, 4'd5, 1'b0, 1'b1);
        check_out("first_after_reset", 1'b1, 4'd5, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
